// File: rtl/t_chain_pkg.sv
// t_chain_pkg: shared fixed-point types and constants for the forward-kinematics
// chain (t_block consumers use the same definitions).
//   fixed_t   - Q19.8 signed element, 27 bits
//   matrix_t  - 4x4 homogeneous transform, indexed [row][col]
//   FIX_ONE   - 1.0 in Q19.8
//   IDENTITY  - 4x4 identity in Q19.8
//   state_t   - accumulator FSM states
package t_chain_pkg;

    localparam int FIX_W    = 27;
    localparam int FIX_FRAC = 8;

    typedef logic signed [FIX_W-1:0] fixed_t;
    typedef fixed_t [3:0][3:0]       matrix_t;

    localparam fixed_t FIX_ONE = 27'sd256;

    // Counter value on which R is folded into A; elements are issued while k < 16.
    localparam logic [4:0] K_LAST = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    function automatic matrix_t identity_matrix();
        matrix_t m;
        m = '0;
        for (int d = 0; d < 4; d++) begin
            m[d][d] = FIX_ONE;
        end
        return m;
    endfunction

    localparam matrix_t IDENTITY = identity_matrix();

endpackage

// File: rtl/t_chain_dot4_q8.sv
// dot4_q8: pipelined 4-wide signed dot product with Q.FRAC round-half-up.
//   clk, reset_n        - clock, asynchronous active-low reset
//   in_valid, in_index  - issue strobe and element index carried alongside
//   a, b                - two 4-element signed operand vectors
//   out_valid, out_index- side-band delayed by the two pipeline stages
//   result              - rounded sum of the four products, wrapped to W bits
module dot4_q8
    import t_chain_pkg::*;
#(
    parameter int W    = 27,
    parameter int FRAC = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [3:0]          in_index,
    input  logic [3:0][W-1:0]   a,
    input  logic [3:0][W-1:0]   b,
    output logic                out_valid,
    output logic [3:0]          out_index,
    output logic [W-1:0]        result
);

    logic [3:0][2*W-1:0] prod;
    logic                prod_valid;
    logic [3:0]          prod_index;

    // Full-width products are summed with two guard bits so the four-term sum
    // never overflows before rounding; the final slice wraps modulo 2^W.
    function automatic logic [W-1:0] sum_round(input logic [3:0][2*W-1:0] p);
        logic [2*W+1:0] s;
        s = '0;
        for (int m = 0; m < 4; m++) begin
            s = s + {{2{p[m][2*W-1]}}, p[m]};
        end
        return s[W+FRAC-1:FRAC] + {{(W-1){1'b0}}, s[FRAC-1]};
    endfunction

    // Stage 1: signed products, operands sign-extended to the product width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            prod_index <= '0;
        end else begin
            for (int m = 0; m < 4; m++) begin
                prod[m] <= {{W{a[m][W-1]}}, a[m]} * {{W{b[m][W-1]}}, b[m]};
            end
            prod_valid <= in_valid;
            prod_index <= in_index;
        end
    end

    // Stage 2: accumulate and round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result    <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
        end else begin
            result    <= sum_round(prod);
            out_valid <= prod_valid;
            out_index <= prod_index;
        end
    end

endmodule

// File: rtl/t_chain.sv
// t_chain: forward-kinematics accumulator, A <= A * T for each accepted link.
//   clk, reset_n             - clock, asynchronous active-low reset
//   in_valid/in_ready        - link handshake; t_matrix, in_first, in_last qualified by in_valid
//   in_first                 - multiply onto identity instead of the retained A
//   in_last                  - present A on the output after this link
//   out_valid/out_ready      - result handshake
//   out_matrix               - registered accumulator A
// Each link takes 18 CALC cycles: 16 element issues into a shared dot4_q8 and
// two cycles of pipeline drain, then A is replaced by the scratch buffer R.
module t_chain
    import t_chain_pkg::*;
#(
    parameter int W    = 27,
    parameter int FRAC = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0][3:0][W-1:0]   t_matrix,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0][3:0][W-1:0]   out_matrix
);

    localparam logic [W-1:0] ONE_W = W'(1) << FRAC;

    state_t                  state;
    state_t                  state_next;
    logic [4:0]              k;
    logic [3:0][3:0][W-1:0]  t_reg;
    logic [3:0][3:0][W-1:0]  a_reg;
    logic [3:0][3:0][W-1:0]  r_reg;
    logic [3:0][3:0][W-1:0]  r_next;
    logic                    last_flag;
    logic                    use_ident;
    logic                    accept;
    logic                    calc_done;

    logic [1:0]              row_sel;
    logic [1:0]              col_sel;
    logic                    issue_valid;
    logic [3:0][W-1:0]       a_vec;
    logic [3:0][W-1:0]       b_vec;
    logic                    res_valid;
    logic [3:0]              res_index;
    logic [W-1:0]            res;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == OUT);
    assign out_matrix  = a_reg;
    assign accept      = in_valid && in_ready;
    assign calc_done   = (state == CALC) && (k == K_LAST);
    assign row_sel     = k[3:2];
    assign col_sel     = k[1:0];
    assign issue_valid = (state == CALC) && !k[4];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one link per IDLE->CALC pass, OUT only after a last link.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (k == K_LAST) begin
                    state_next = last_flag ? OUT : IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Link capture and element counter. T and the flags only change on accept,
    // so upstream activity during CALC/OUT cannot disturb the running link.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k         <= '0;
            t_reg     <= '0;
            last_flag <= 1'b0;
            use_ident <= 1'b0;
        end else begin
            if (accept) begin
                t_reg     <= t_matrix;
                last_flag <= in_last;
                use_ident <= in_first;
                k         <= '0;
            end else if (state == CALC) begin
                k <= (k == K_LAST) ? '0 : k + 5'd1;
            end
        end
    end

    // Operand select: row i of the left operand (identity for a first link,
    // otherwise A) against column j of T.
    always_comb begin
        a_vec = '0;
        b_vec = '0;
        for (int m = 0; m < 4; m++) begin
            if (use_ident) begin
                a_vec[m] = (row_sel == 2'(m)) ? ONE_W : '0;
            end else begin
                a_vec[m] = a_reg[row_sel][m];
            end
            b_vec[m] = t_reg[m][col_sel];
        end
    end

    dot4_q8 #(
        .W    (W),
        .FRAC (FRAC)
    ) u_dot (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (issue_valid),
        .in_index  (k[3:0]),
        .a         (a_vec),
        .b         (b_vec),
        .out_valid (res_valid),
        .out_index (res_index),
        .result    (res)
    );

    // The last element lands in the same cycle A is replaced, so A is loaded
    // from R with the pending write merged in.
    always_comb begin
        r_next = r_reg;
        if (res_valid) begin
            r_next[res_index[3:2]][res_index[1:0]] = res;
        end
    end

    // Scratch buffer R collects the new product element by element.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg <= '0;
        end else begin
            r_reg <= r_next;
        end
    end

    // Accumulator A: identity after reset, replaced only at the end of CALC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    a_reg[r][c] <= (r == c) ? ONE_W : '0;
                end
            end
        end else if (calc_done) begin
            a_reg <= r_next;
        end
    end

endmodule

// File: tb/tb_t_chain.sv
// tb_t_chain: self-checking bench for t_chain.
// Directed vectors with hand-computed results, backpressure and mid-CALC reset
// sequences, then random links compared against a matrix-arithmetic model.
module tb_t_chain;
    import t_chain_pkg::*;

    typedef longint lmat_t [4][4];

    typedef struct {
        string   name;
        matrix_t t;
        bit      first;
        bit      last;
        matrix_t expected;
    } vec_t;

    logic    clk       = 1'b0;
    logic    reset_n   = 1'b1;
    logic    in_valid  = 1'b0;
    logic    in_first  = 1'b0;
    logic    in_last   = 1'b0;
    logic    out_ready = 1'b0;
    logic    in_ready;
    logic    out_valid;
    matrix_t t_matrix  = '0;
    matrix_t out_matrix;

    int      checks = 0;
    int      errors = 0;
    lmat_t   model_a;

    t_chain #(
        .W    (27),
        .FRAC (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .t_matrix   (t_matrix),
        .in_first   (in_first),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_matrix (out_matrix)
    );

    always #5 clk = ~clk;

    // Overall time bound in case the DUT never returns to IDLE.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic fixed_t fx(input int v);
        return v[26:0];
    endfunction

    function automatic matrix_t ident_m();
        matrix_t m;
        m = '0;
        for (int d = 0; d < 4; d++) m[d][d] = fx(256);
        return m;
    endfunction

    function automatic lmat_t ident_l();
        lmat_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = (r == c) ? 64'sd256 : 64'sd0;
        return m;
    endfunction

    function automatic lmat_t to_l(input matrix_t m);
        lmat_t l;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                l[r][c] = longint'(m[r][c]);
        return l;
    endfunction

    // Reference: exact integer matrix product, round half up at 2^-8, wrap to 27 bits.
    function automatic lmat_t model_mul(input lmat_t a, input lmat_t t);
        lmat_t  res;
        longint s;
        longint q;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int m = 0; m < 4; m++) s += a[i][m] * t[m][j];
                q = (s >>> 8) + ((s >>> 7) & 64'sd1);
                q = q & 64'sh7FF_FFFF;
                if (q >= 64'sh400_0000) q = q - 64'sh800_0000;
                res[i][j] = q;
            end
        end
        return res;
    endfunction

    function automatic matrix_t rand_mat(input bit wide);
        matrix_t     m;
        int          v;
        logic [31:0] u;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (wide) begin
                    u = $urandom();
                    m[r][c] = u[26:0];
                end else begin
                    v = int'($urandom_range(0, 2048)) - 1024;
                    m[r][c] = fx(v);
                end
            end
        end
        return m;
    endfunction

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0b, want %0b", name, actual, expected);
        end
    endtask

    task automatic check_output(input string name, input lmat_t expected);
        int     bad = 0;
        int     br = 0;
        int     bc = 0;
        lmat_t  got;
        got = to_l(out_matrix);
        checks++;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (got[r][c] != expected[r][c] || $isunknown(out_matrix[r][c])) begin
                    if (bad == 0) begin
                        br = r;
                        bc = c;
                    end
                    bad++;
                end
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d elements differ, [%0d][%0d] got %0d want %0d",
                     name, bad, br, bc, got[br][bc], expected[br][bc]);
        end
    endtask

    // Sends one link, drives junk upstream/downstream traffic during CALC,
    // then checks the cycle-19 handshake state and the accumulator.
    task automatic apply_stimulus(input matrix_t t, input bit first, input bit last,
                                  input string name);
        int waited   = 0;
        int busy_bad = 0;
        while (in_ready !== 1'b1 && waited < 64) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_bit({name, " accept ready"}, in_ready, 1'b1);
        if (in_ready !== 1'b1) return;
        t_matrix = t;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        model_a = model_mul(first ? ident_l() : model_a, to_l(t));
        for (int c = 1; c <= 18; c++) begin
            in_valid  = (c < 18) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_first  = 1'($urandom_range(0, 1));
            in_last   = 1'($urandom_range(0, 1));
            t_matrix  = rand_mat(1'b1);
            out_ready = (c < 18) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("[TB] FAIL %s busy window: %0d cycles with in_ready/out_valid high, want 0",
                     name, busy_bad);
        end
        @(negedge clk);
        check_bit({name, " out_valid c19"}, out_valid, last);
        check_bit({name, " in_ready c19"}, in_ready, !last);
        check_output({name, " model"}, model_a);
    endtask

    task automatic consume_output(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_bit({name, " idle ready"}, in_ready, 1'b1);
        check_bit({name, " idle out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        vec_t    vecs[7];
        matrix_t m;
        matrix_t e;
        int      bp_bad;
        bit      first;
        bit      last;

        // Directed vectors with hand-computed results.
        m = ident_m(); m[0][3] = fx(512); m[2][3] = fx(768);
        vecs[0] = '{"single link", m, 1'b1, 1'b1, m};
        m = ident_m(); m[0][3] = fx(256);
        vecs[1] = '{"translate 1", m, 1'b1, 1'b0, ident_m()};
        m = ident_m(); m[0][3] = fx(768);
        e = ident_m(); e[0][3] = fx(1024);
        vecs[2] = '{"translate 2", m, 1'b0, 1'b1, e};
        m = '0; m[0][0] = fx(181); m[1][1] = fx(181); m[2][2] = fx(181); m[3][3] = fx(256);
        e = '0; e[0][0] = fx(128); e[1][1] = fx(128); e[2][2] = fx(128); e[3][3] = fx(256);
        vecs[3] = '{"rotate pos 1", m, 1'b1, 1'b0, ident_m()};
        vecs[4] = '{"rotate pos 2", m, 1'b0, 1'b1, e};
        vecs[5] = '{"rotate neg 1", m, 1'b1, 1'b0, ident_m()};
        m[0][0] = fx(-181);
        e[0][0] = fx(-128);
        vecs[6] = '{"rotate neg 2", m, 1'b0, 1'b1, e};

        // Asynchronous reset, checked before any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check_bit("reset in_ready", in_ready, 1'b1);
        check_bit("reset out_valid", out_valid, 1'b0);
        check_output("reset matrix", ident_l());
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_a = ident_l();

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].t, vecs[i].first, vecs[i].last, vecs[i].name);
            if (vecs[i].last) begin
                check_output({vecs[i].name, " expected"}, to_l(vecs[i].expected));
                if (i == 0) begin
                    // Hold the output while upstream keeps offering links.
                    bp_bad = 0;
                    for (int c = 0; c < 10; c++) begin
                        in_valid = (c % 2 == 0);
                        in_first = 1'b1;
                        in_last  = 1'b1;
                        t_matrix = rand_mat(1'b1);
                        @(posedge clk);
                        #1;
                        @(negedge clk);
                        if (in_ready !== 1'b0 || out_valid !== 1'b1) bp_bad++;
                        if (to_l(out_matrix) != model_a) bp_bad++;
                    end
                    in_valid = 1'b0;
                    checks++;
                    if (bp_bad != 0) begin
                        errors++;
                        $display("[TB] FAIL backpressure hold: %0d violations, want 0", bp_bad);
                    end
                    consume_output("backpressure");
                    check_output("backpressure retained A", model_a);
                end else begin
                    consume_output(vecs[i].name);
                end
            end
        end

        // Random chains, including links that accumulate onto a retained A.
        for (int n = 0; n < 24; n++) begin
            first = (n == 0) || ($urandom_range(0, 3) == 0);
            last  = ($urandom_range(0, 2) == 0);
            apply_stimulus(rand_mat(1'($urandom_range(0, 1))), first, last, "random link");
            if (last) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                consume_output("random out");
            end
        end

        // Reset at k = 7 of a last link.
        @(posedge clk);
        #1;
        t_matrix = rand_mat(1'b0);
        in_first = 1'b1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_bit("mid-calc reset in_ready", in_ready, 1'b1);
        check_bit("mid-calc reset out_valid", out_valid, 1'b0);
        check_output("mid-calc reset matrix", ident_l());
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_a = ident_l();
        m = rand_mat(1'b1);
        apply_stimulus(m, 1'b1, 1'b1, "post-reset link");
        check_output("post-reset equals T", to_l(m));
        consume_output("post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/t_chain.md
# t_chain

Forward-kinematics accumulator that sits directly downstream of `t_block`. It consumes a sequence of per-link 4x4 DH transformation matrices (Q19.8, 27-bit signed) and multiplies them in order, A ← A·T. After the last link it presents the base-to-end-effector matrix. One shared 4-wide dot-product unit computes one output element per cycle, so each link takes a fixed 19 cycles.

## Interface

Parameters:
- `W`, default 27: element width, signed two's complement.
- `FRAC`, default 8: fractional bits; 1.0 = 256.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: `t_matrix`, `in_first` and `in_last` are valid.
- `in_ready`  out  1: block can accept a link.
- `t_matrix`  in  4x4xW: link transform, indexed [row][col].
- `in_first`  in  1: start a new chain (A treated as identity before this multiply).
- `in_last`  in  1: final link of the chain; result goes to the output.
- `out_valid`  out  1: `out_matrix` holds a completed chain.
- `out_ready`  in  1: consumer accepts the output.
- `out_matrix`  out  4x4xW: accumulator A, registered.

## Operation

- Handshake:
  - A link is accepted when `in_valid && in_ready`.
  - The output is consumed when `out_valid && out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == OUT).
- States and transitions:
  - IDLE → CALC on accept. In that cycle: latch `t_matrix` into register T and latch `in_last`. Set the operand source to identity if `in_first`, otherwise to A.
  - CALC: counter k runs 0..17.
    - Cycles k = 0..15 issue element (i,j) = (k>>2, k&3), row-major.
    - Dot product: sum over m of A[i][m]·T[m][j].
    - Results are written into scratch buffer R two cycles after issue (one multiply stage, one add/round stage).
  - CALC end: at k = 17, copy R into A. Go to OUT if the latched last flag is set, else to IDLE.
  - OUT → IDLE on `out_ready`.
- Arithmetic, per element:
  - Four full-width 2W-bit products are summed into a (2W+2)-bit accumulator s.
  - Rounding: result = s[W+FRAC-1:FRAC] + s[FRAC-1] (round half up, same rule as `t_block`).
  - Overflow wraps modulo 2^W; there is no saturation.
- A is never written during CALC. R exists so that row i of A stays intact while row i of the result is computed.
- Boundary conditions:
  - `in_valid` during CALC or OUT: ignored, not latched; upstream must hold the link.
  - `in_first && in_last`: the result is T exactly (identity multiply is exact).
  - Link without `in_first` after a completed chain: accumulates onto the retained A. This is legal.
  - `out_ready` high outside OUT: no effect.
- Reset, including mid-CALC or mid-OUT:
  - state = IDLE, k = 0, T = 0, R = 0, last flag = 0.
  - A = identity (diagonal 256, all else 0).
  - Any partial result is discarded.

## Timing

- Accept at cycle 0 → A updated at the end of cycle 18 → `out_valid` high in cycle 19 when last.
- Non-last links: `in_ready` is high again in cycle 19. Throughput is one link per 19 cycles plus the handshake.
- `out_matrix` is stable for the whole of OUT and only changes at the end of CALC.
- No combinational path from inputs to outputs. `in_ready` and `out_valid` are decoded from registered state.
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_matrix` = identity.

## Structure

- Package `t_chain_pkg`:
  - `fixed_t` (logic signed [W-1:0]).
  - `matrix_t` (fixed_t [3:0][3:0]).
  - `FIX_ONE` = 256.
  - `IDENTITY` matrix constant.
  - State enum {IDLE, CALC, OUT}.
  - Shared with `t_block` consumers.
- Sub-module `dot4_q8`:
  - Inputs: two 4-element fixed_t vectors and a valid bit.
  - Stages: registered products, then registered sum and round.
  - Latency 2, with a valid and index side-band carried alongside.
- Top level: FSM, counter, T/A/R registers, operand muxing.

## Test plan

1. **Reset.** Assert `reset_n` = 0 asynchronously. Required: `in_ready` = 1, `out_valid` = 0, and `out_matrix` diagonal = 256, off-diagonal = 0, without waiting for a clock edge.
2. **Single-link chain.** T = identity with [0][3] = 512 and [2][3] = 768, sent with first and last. Required: `out_valid` in cycle 19 and `out_matrix` == T bit-exact.
3. **Two translations.** Link 1 (first) has [0][3] = 256; link 2 (last) has [0][3] = 768. Required: output [0][3] = 1024, diagonal = 256, everything else 0. `in_ready` must be low for cycles 1–18 of each link.
4. **Rounding and sign.** Two links, each diagonal 181 with [3][3] = 256. Required: output [0][0] = 128. Repeat with link 2 having [0][0] = −181. Required: output [0][0] = −128.
5. **Backpressure.** After `out_valid` rises, hold `out_ready` = 0 for 10 cycles while pulsing `in_valid`. Required: `out_matrix` stable, `in_ready` = 0, and no link accepted. Then drive `out_ready` = 1. Required: IDLE on the next cycle.
6. **Reset mid-CALC.** Deassert `reset_n` at k = 7 of a last link. Required: immediate return to IDLE with `out_valid` = 0 and A = identity. A following single-link chain must produce a correct result.
